// File: rtl/fetch_stage.sv
// fetch_stage: WISC instruction-fetch stage owning the PC and the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the saturating fetch_cnt_o/stall_cnt_o counters.
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] NOP_INST = 16'h0800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [PC_W-1:0] imem_data_i,
  output logic [PC_W-1:0] ifid_inst_o,
  output logic [PC_W-1:0] ifid_pc_plus2_o,
  output logic            ifid_valid_o,
  output logic            halted_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]     fetch_cnt_o,
  output logic [15:0]     stall_cnt_o,
`endif
  output logic            err_o
);
  typedef enum logic {RUN, HALTED} state_e;
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, inst_q, inst_d, pp2_q, pp2_d;
  logic valid_q, valid_d, err_q, err_d, load, stall_cyc;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    pp2_d = pp2_q;
    valid_d = valid_q;
    err_d = err_q;
    load = 1'b0;
    stall_cyc = 1'b0;
    if (state_q == RUN) begin
      if (halt_i) begin
        state_d = HALTED;
        valid_d = 1'b0;
        inst_d = NOP_INST;
      end else if (redirect_i) begin
        pc_d = {redirect_pc_i[PC_W-1:1], 1'b0};
        valid_d = 1'b0;
        inst_d = NOP_INST;
        err_d = err_q | redirect_pc_i[0];
      end else if (stall_i) begin
        stall_cyc = 1'b1;
      end else begin
        load = 1'b1;
        inst_d = imem_data_i;
        pp2_d = pc_q + PC_W'(2);
        valid_d = 1'b1;
        pc_d = pc_q + PC_W'(2);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      inst_q <= NOP_INST;
      pp2_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      pp2_q <= pp2_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fcnt_q, scnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      fcnt_q <= (load && fcnt_q != 16'hFFFF) ? fcnt_q + 16'd1 : fcnt_q;
      scnt_q <= (stall_cyc && scnt_q != 16'hFFFF) ? scnt_q + 16'd1 : scnt_q;
    end
  end
  assign fetch_cnt_o = fcnt_q;
  assign stall_cnt_o = scnt_q;
`else
  logic unused_ok;
  assign unused_ok = load | stall_cyc;
`endif
  assign imem_addr_o = pc_q;
  assign ifid_inst_o = inst_q;
  assign ifid_pc_plus2_o = pp2_q;
  assign ifid_valid_o = valid_q;
  assign halted_o = (state_q == HALTED);
  assign err_o = err_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, halt/wrap sequences and a randomized run against a reference model.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst, stall, redir, halt, rst2;
  logic [15:0] rpc, addr, data, inst, pp2, addr2, data2, inst2, pp22;
  logic valid, halted, err, valid2, halted2, err2;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fcnt, scnt, fcnt2, scnt2;
`endif
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return 16'hA001 + (a >> 1);
  endfunction
  assign data = mem(addr);
  assign data2 = mem(addr2);

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(rpc),
    .halt_i(halt), .imem_addr_o(addr), .imem_data_i(data), .ifid_inst_o(inst),
    .ifid_pc_plus2_o(pp2), .ifid_valid_o(valid), .halted_o(halted),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o(fcnt), .stall_cnt_o(scnt),
`endif
    .err_o(err)
  );

  fetch_stage #(.RESET_PC(16'hFFFC)) u_wrap (
    .clk(clk), .rst(rst2), .stall_i(1'b0), .redirect_i(1'b0), .redirect_pc_i(16'h0000),
    .halt_i(1'b0), .imem_addr_o(addr2), .imem_data_i(data2), .ifid_inst_o(inst2),
    .ifid_pc_plus2_o(pp22), .ifid_valid_o(valid2), .halted_o(halted2),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o(fcnt2), .stall_cnt_o(scnt2),
`endif
    .err_o(err2)
  );

  typedef struct {
    logic rst, stall, redir;
    logic [15:0] rpc;
    logic halt;
    logic [15:0] pc, inst, pp2;
    logic valid, halted, err;
  } vec_t;
  vec_t v[16];

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h @%0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] m_pc, m_inst, m_pp2, m_fc, m_sc;
  logic m_valid, m_halted, m_err;

  initial begin
    rst = 1'b1; rst2 = 1'b1; stall = 1'b0; redir = 1'b0; halt = 1'b0; rpc = 16'h0000;
    //       rst stall redir rpc   halt pc     inst   pp2   v h e
    v[0]  = '{1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0000, 0, 0, 0};
    v[1]  = '{0, 0, 0, 16'h0000, 0, 16'h0002, 16'hA001, 16'h0002, 1, 0, 0};
    v[2]  = '{0, 0, 0, 16'h0000, 0, 16'h0004, 16'hA002, 16'h0004, 1, 0, 0};
    v[3]  = '{0, 1, 0, 16'h0000, 0, 16'h0004, 16'hA002, 16'h0004, 1, 0, 0};
    v[4]  = '{0, 1, 0, 16'h0000, 0, 16'h0004, 16'hA002, 16'h0004, 1, 0, 0};
    v[5]  = '{0, 0, 0, 16'h0000, 0, 16'h0006, 16'hA003, 16'h0006, 1, 0, 0};
    v[6]  = '{0, 1, 1, 16'h0040, 0, 16'h0040, 16'h0800, 16'h0006, 0, 0, 0};
    v[7]  = '{0, 0, 0, 16'h0000, 0, 16'h0042, 16'hA021, 16'h0042, 1, 0, 0};
    v[8]  = '{0, 0, 1, 16'h0031, 0, 16'h0030, 16'h0800, 16'h0042, 0, 0, 1};
    v[9]  = '{0, 0, 0, 16'h0000, 0, 16'h0032, 16'hA019, 16'h0032, 1, 0, 1};
    v[10] = '{1, 1, 1, 16'h0077, 0, 16'h0000, 16'h0800, 16'h0000, 0, 0, 0};
    v[11] = '{0, 0, 0, 16'h0000, 0, 16'h0002, 16'hA001, 16'h0002, 1, 0, 0};
    v[12] = '{0, 0, 0, 16'h0000, 0, 16'h0004, 16'hA002, 16'h0004, 1, 0, 0};
    v[13] = '{0, 0, 0, 16'h0000, 0, 16'h0006, 16'hA003, 16'h0006, 1, 0, 0};
    v[14] = '{0, 0, 0, 16'h0000, 0, 16'h0008, 16'hA004, 16'h0008, 1, 0, 0};
    v[15] = '{0, 0, 0, 16'h0000, 1, 16'h0008, 16'h0800, 16'h0008, 0, 1, 0};
    for (int i = 0; i < 16; i++) begin
      rst = v[i].rst; stall = v[i].stall; redir = v[i].redir; rpc = v[i].rpc; halt = v[i].halt;
      tick();
      chk($sformatf("vec%0d.pc", i), addr, v[i].pc);
      chk($sformatf("vec%0d.inst", i), inst, v[i].inst);
      chk($sformatf("vec%0d.pp2", i), pp2, v[i].pp2);
      chk($sformatf("vec%0d.valid", i), {15'd0, valid}, {15'd0, v[i].valid});
      chk($sformatf("vec%0d.halted", i), {15'd0, halted}, {15'd0, v[i].halted});
      chk($sformatf("vec%0d.err", i), {15'd0, err}, {15'd0, v[i].err});
`ifdef FETCH_PERF_CNT_EN
      if (i == 5) begin
        chk("perf.fetch", fcnt, 16'd3);
        chk("perf.stall", scnt, 16'd2);
      end
`endif
    end
    // HALTED ignores everything but rst
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom); redir = 1'($urandom); rpc = 16'($urandom); halt = 1'($urandom);
      tick();
      chk("halt.pc", addr, 16'h0008);
      chk("halt.valid", {15'd0, valid}, 16'd0);
      chk("halt.halted", {15'd0, halted}, 16'd1);
      chk("halt.err", {15'd0, err}, 16'd0);
    end
    rst = 1'b1; stall = 1'b0; redir = 1'b0; halt = 1'b0;
    tick();
    chk("halt.rst.pc", addr, 16'h0000);
    chk("halt.rst.halted", {15'd0, halted}, 16'd0);
    rst = 1'b0;
    // wrap-around instance
    tick();
    chk("wrap.rst.pc", addr2, 16'hFFFC);
    rst2 = 1'b0;
    tick();
    chk("wrap.pc1", addr2, 16'hFFFE);
    chk("wrap.inst1", inst2, mem(16'hFFFC));
    chk("wrap.pp2_1", pp22, 16'hFFFE);
    tick();
    chk("wrap.pc2", addr2, 16'h0000);
    chk("wrap.pp2_2", pp22, 16'h0000);
    chk("wrap.err", {15'd0, err2}, 16'd0);
    // randomized run against the model
    for (int c = 0; c < 600; c++) begin
      rst = (c == 0) || ($urandom_range(0, 29) == 0);
      halt = ($urandom_range(0, 39) == 0);
      redir = !halt && ($urandom_range(0, 5) == 0);
      stall = ($urandom_range(0, 3) == 0);
      rpc = 16'($urandom);
      if (rst) begin
        m_pc = 16'h0000; m_inst = 16'h0800; m_pp2 = 16'h0000;
        m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_fc = 16'd0; m_sc = 16'd0;
      end else if (!m_halted) begin
        if (halt) begin
          m_halted = 1'b1; m_valid = 1'b0; m_inst = 16'h0800;
        end else if (redir) begin
          m_pc = rpc & 16'hFFFE; m_err = m_err | rpc[0]; m_valid = 1'b0; m_inst = 16'h0800;
        end else if (stall) begin
          m_sc = (m_sc == 16'hFFFF) ? m_sc : m_sc + 16'd1;
        end else begin
          m_inst = mem(m_pc); m_pp2 = m_pc + 16'd2; m_pc = m_pc + 16'd2; m_valid = 1'b1;
          m_fc = (m_fc == 16'hFFFF) ? m_fc : m_fc + 16'd1;
        end
      end
      tick();
      chk("rnd.pc", addr, m_pc);
      chk("rnd.inst", inst, m_inst);
      chk("rnd.pp2", pp2, m_pp2);
      chk("rnd.valid", {15'd0, valid}, {15'd0, m_valid});
      chk("rnd.halted", {15'd0, halted}, {15'd0, m_halted});
      chk("rnd.err", {15'd0, err}, {15'd0, m_err});
`ifdef FETCH_PERF_CNT_EN
      chk("rnd.fcnt", fcnt, m_fc);
      chk("rnd.scnt", scnt, m_sc);
`endif
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage for the pipelined WISC processor. Sits directly upstream of decode/register-read.
- Owns the PC register and drives the instruction-memory address. Latches instruction + PC+2 into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch/jump redirects (flushes) and HALT freeze.

Parameters:
- PC_W, 16, width of PC and instruction word.
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'h0800, encoding inserted into IF/ID on flush/reset (WISC NOP).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  hazard unit: hold PC and IF/ID
- redirect_i  in  1  taken branch/jump resolved downstream
- redirect_pc_i  in  PC_W  redirect target
- halt_i  in  1  HALT retired downstream; freeze fetch
- imem_addr_o  out  PC_W  instruction-memory address (= PC register)
- imem_data_i  in  PC_W  instruction-memory read data, combinational w.r.t. imem_addr_o
- ifid_inst_o  out  PC_W  registered instruction
- ifid_pc_plus2_o  out  PC_W  registered PC+2 of that instruction
- ifid_valid_o  out  1  IF/ID holds a real instruction
- halted_o  out  1  stage in HALTED state
- err_o  out  1  sticky: misaligned redirect target seen

Behaviour:
- Reset (sync, rst=1 at posedge):
  - PC=RESET_PC; ifid_inst_o=NOP_INST; ifid_pc_plus2_o=0; ifid_valid_o=0.
  - State=RUN; halted_o=0; err_o=0.
- FSM: RUN, HALTED.
  - RUN->HALTED when halt_i=1.
  - HALTED exits only via rst.
- Per-posedge priority, in RUN: rst > halt_i > redirect_i > stall_i > normal.
  - halt_i: PC holds; ifid_valid_o<=0; ifid_inst_o<=NOP_INST; state<=HALTED.
  - redirect_i: PC<=redirect_pc_i with bit0 forced 0; ifid_valid_o<=0; ifid_inst_o<=NOP_INST (flush wrong-path fetch). Overrides stall_i in the same cycle.
  - stall_i: PC and all IF/ID outputs hold their values exactly.
  - normal: ifid_inst_o<=imem_data_i; ifid_pc_plus2_o<=PC+2; ifid_valid_o<=1; PC<=PC+2.
- In HALTED: all inputs except rst ignored; PC and IF/ID frozen; halted_o=1.
- Arithmetic: PC+2 is modulo 2^PC_W; 16'hFFFE+2 = 16'h0000, no error.
- err_o: set on a cycle with redirect_i=1 and redirect_pc_i[0]=1; sticky until rst. Does not stop fetch.
- Latency:
  - Redirect target appears on imem_addr_o the cycle after redirect_i.
  - Its instruction is valid in IF/ID one cycle later: 1-cycle bubble.
- imem_addr_o is purely the PC register; no combinational path from any input.
- rst mid-stall or mid-redirect: reset values win, no partial update.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt_o[15:0] and stall_cnt_o[15:0].
  - Both reset to 0 and saturate at 16'hFFFF.
  - fetch_cnt_o increments on each normal-path load (ifid_valid_o<=1).
  - stall_cnt_o increments on each RUN cycle with stall_i=1 and no redirect_i/halt_i.
  - Neither counter increments in HALTED.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then 3 free-run cycles, imem returns 16'hA001, 16'hA002, 16'hA003:
  - imem_addr_o goes 0,2,4,6.
  - IF/ID shows {A001,0002,1}, {A002,0004,1}, {A003,0006,1}.
- stall_i high for 2 cycles at PC=4: PC stays 4 and IF/ID unchanged for both cycles; normal sequence resumes after.
- redirect_i=1, redirect_pc_i=16'h0040 together with stall_i=1:
  - Next cycle PC=0x0040, ifid_valid_o=0, ifid_inst_o=0x0800.
  - Following cycle IF/ID = imem[0x40] with pc_plus2 = 0x0042.
- redirect_pc_i=16'h0031: PC=0x0030 and err_o=1, staying 1 until rst.
- halt_i pulse at PC=8: halted_o=1; PC stays 8 and ifid_valid_o=0 for 10 cycles despite redirect/stall toggling; rst returns PC=0 and halted_o=0.
- Start at RESET_PC=16'hFFFC: sequence FFFC, FFFE, 0000 with err_o=0. With FETCH_PERF_CNT_EN: fetch_cnt_o=3 after 3 loads, stall_cnt_o=2 after the stall test.
